// File: rtl/memory_arbiter.sv
// Arbitrates one instruction-fetch port and one data port onto a single backing-memory bus.
// Data wins when both are eligible; misaligned requests fault immediately and never reach memory.
module memory_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iReq,
  input  logic [31:0] iAddr,
  output logic [31:0] iData,
  output logic        iStall,
  output logic        iException,
  input  logic        dReq,
  input  logic        dWrite,
  input  logic [1:0]  dSize,
  input  logic [31:0] dAddr,
  input  logic [31:0] dWdata,
  output logic [31:0] dRdata,
  output logic        dStall,
  output logic        dException,
  input  logic        pipeAdvance,
  output logic        memReq,
  output logic        memWrite,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  output logic [3:0]  memStrb,
  input  logic [31:0] memRdata,
  input  logic        memAck
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] I_BUSY = 2'd1;
  localparam logic [1:0] D_BUSY = 2'd2;

  localparam logic [9:0] CNT_LAST = 10'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic        i_done_q, i_done_d, i_err_q, i_err_d;
  logic        d_done_q, d_done_d, d_err_q, d_err_d;
  logic        mem_req_q, mem_req_d, mem_write_q, mem_write_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_strb_q, mem_strb_d;
  logic [31:0] i_data_q, i_data_d, d_rdata_q, d_rdata_d;

  logic        i_mis, d_mis, i_elig, d_elig;
  logic [3:0]  d_strb;
  logic [31:0] d_wdata_rep;

  assign i_mis  = iReq & (iAddr[1:0] != 2'b00);
  assign d_mis  = dReq & ((dSize == 2'b11) |
                          ((dSize == 2'b01) & dAddr[0]) |
                          ((dSize == 2'b10) & (dAddr[1:0] != 2'b00)));
  assign i_elig = iReq & ~i_mis & ~i_done_q;
  assign d_elig = dReq & ~d_mis & ~d_done_q;

  always_comb begin
    d_strb      = 4'b1111;
    d_wdata_rep = dWdata;
    case (dSize)
      2'b00: begin
        d_strb      = 4'b0001 << dAddr[1:0];
        d_wdata_rep = {4{dWdata[7:0]}};
      end
      2'b01: begin
        d_strb      = dAddr[1] ? 4'b1100 : 4'b0011;
        d_wdata_rep = {2{dWdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    i_done_d    = i_done_q;
    i_err_d     = i_err_q;
    d_done_d    = d_done_q;
    d_err_d     = d_err_q;
    mem_req_d   = mem_req_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_strb_d  = mem_strb_q;
    i_data_d    = i_data_q;
    d_rdata_d   = d_rdata_q;

    // Completion flags live until the pipeline consumes them; a completion below overrides the clear.
    if (pipeAdvance) begin
      i_done_d = 1'b0;
      i_err_d  = 1'b0;
      d_done_d = 1'b0;
      d_err_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (d_elig) begin
          state_d     = D_BUSY;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_write_d = dWrite;
          mem_addr_d  = {dAddr[31:2], 2'b00};
          mem_wdata_d = d_wdata_rep;
          mem_strb_d  = dWrite ? d_strb : 4'b0000;
        end else if (i_elig) begin
          state_d     = I_BUSY;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_write_d = 1'b0;
          mem_addr_d  = {iAddr[31:2], 2'b00};
          mem_wdata_d = '0;
          mem_strb_d  = 4'b0000;
        end
      end
      I_BUSY, D_BUSY: begin
        if (memAck || cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (state_q == I_BUSY) begin
            i_done_d = 1'b1;
            i_err_d  = ~memAck;
            if (memAck) i_data_d = memRdata;
          end else begin
            d_done_d = 1'b1;
            d_err_d  = ~memAck;
            if (memAck) d_rdata_d = memRdata;
          end
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      i_done_q    <= 1'b0;
      i_err_q     <= 1'b0;
      d_done_q    <= 1'b0;
      d_err_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_strb_q  <= 4'b0000;
      i_data_q    <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      i_done_q    <= i_done_d;
      i_err_q     <= i_err_d;
      d_done_q    <= d_done_d;
      d_err_q     <= d_err_d;
      mem_req_q   <= mem_req_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_strb_q  <= mem_strb_d;
      i_data_q    <= i_data_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign iStall     = ~rst & i_elig;
  assign dStall     = ~rst & d_elig;
  assign iException = ~rst & (i_mis | (i_done_q & i_err_q));
  assign dException = ~rst & (d_mis | (d_done_q & d_err_q));

  assign iData    = i_data_q;
  assign dRdata   = d_rdata_q;
  assign memReq   = mem_req_q;
  assign memWrite = mem_write_q;
  assign memAddr  = mem_addr_q;
  assign memWdata = mem_wdata_q;
  assign memStrb  = mem_strb_q;

endmodule
